// File: rtl/seq_mult_8bit_pkg.sv
// Shared definitions for the sequential 8x8 shift-and-add multiplier.
package mult_pkg;

    localparam int unsigned N_BITS    = 8;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned LAST_ITER = 7;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // True on the final iteration of RUN.
    function automatic logic is_last_iter(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(LAST_ITER);
    endfunction

endpackage

// File: rtl/seq_mult_8bit_if.sv
// Start/busy/done handshake and operand/result bus of the multiplier.
interface seq_mult_8bit_if;
    import mult_pkg::*;

    logic                  start;
    logic [N_BITS-1:0]     a;
    logic [N_BITS-1:0]     b;
    logic                  busy;
    logic                  done;
    logic [2*N_BITS-1:0]   product;

    // Controller side drives requests and operands.
    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    // Multiplier side.
    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );

endinterface

// File: rtl/seq_mult_8bit_rca.sv
// 8-bit ripple-carry adder stage used by the multiplier for every iteration.
module RCA_8Bit_Adder
    import mult_pkg::*;
(
    input  logic [N_BITS-1:0] a_i,
    input  logic [N_BITS-1:0] b_i,
    input  logic              c0_i,
    output logic [N_BITS-1:0] s_o,
    output logic              c_o
);

    logic [N_BITS:0] carry;

    // Chain of full adders, carry rippling from bit 0 upwards.
    always_comb begin
        carry    = '0;
        s_o      = '0;
        carry[0] = c0_i;
        for (int i = 0; i < int'(N_BITS); i++) begin
            s_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign c_o = carry[N_BITS];

endmodule

// File: rtl/seq_mult_8bit.sv
// Sequential 8x8 unsigned shift-and-add multiplier, 16-bit product in 8 iterations.
// Optional feature: define MULT_EARLY_DONE_EN to skip RUN when either operand is zero.
module seq_mult_8bit
    import mult_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    seq_mult_8bit_if.slave bus
);

    state_e              state_q;
    logic [N_BITS-1:0]   m_q;
    logic [N_BITS-1:0]   a_q;
    logic [N_BITS-1:0]   q_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                done_q;
    logic [2*N_BITS-1:0] product_q;

    logic [N_BITS-1:0]   addend;
    logic [N_BITS-1:0]   sum;
    logic                carry;
    logic [N_BITS-1:0]   a_d;
    logic [N_BITS-1:0]   q_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                zero_op;

`ifdef MULT_EARLY_DONE_EN
    assign zero_op = (bus.a == '0) || (bus.b == '0);
`else
    assign zero_op = 1'b0;
`endif

    RCA_8Bit_Adder u_rca (
        .a_i  (a_q),
        .b_i  (addend),
        .c0_i (1'b0),
        .s_o  (sum),
        .c_o  (carry)
    );

    // Iteration datapath: add M when the current multiplier bit is set, then shift right.
    always_comb begin
        addend = q_q[0] ? m_q : '0;
        a_d    = {carry, sum[N_BITS-1:1]};
        q_d    = {sum[0], q_q[N_BITS-1:1]};
        cnt_d  = cnt_q + 1'b1;
    end

    // Control FSM with counter, shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        m_q   <= bus.a;
                        q_q   <= bus.b;
                        a_q   <= '0;
                        cnt_q <= '0;
                        if (zero_op) begin
                            // Product is known to be zero; go straight to completion.
                            product_q <= '0;
                            done_q    <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_d;
                    if (is_last_iter(cnt_q)) begin
                        product_q <= {a_d, q_d};
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult_8bit.sv
// Self-checking bench for seq_mult_8bit against a plain-arithmetic reference model.
module tb_seq_mult_8bit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_mult_8bit_if bus ();

    seq_mult_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference latency in edges from acceptance to done high.
    function automatic int ref_latency(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_EARLY_DONE_EN
        if (a == 8'd0 || b == 8'd0) return 0;
`endif
        return 8;
    endfunction

    // Issue one operation from IDLE; optionally wiggle start/operands while it runs.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic noise);
        logic [15:0] exp;
        int          lat;
        exp = 16'(a) * 16'(b);
        lat = ref_latency(a, b);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = noise;
        if (noise) begin
            bus.a = 8'd3;
            bus.b = 8'd3;
        end
        for (int k = 0; k < lat; k++) begin
            chk("busy_run", 16'(bus.busy), 16'd1);
            chk("done_run", 16'(bus.done), 16'd0);
            @(posedge clk); #1;
        end
        chk("done_pulse", 16'(bus.done), 16'd1);
        chk("busy_done", 16'(bus.busy), 16'd0);
        chk("product", bus.product, exp);
        @(posedge clk); #1;
        chk("done_drop", 16'(bus.done), 16'd0);
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", 16'(bus.busy), 16'd0);
        chk("idle_done", 16'(bus.done), 16'd0);
        chk("product_hold", bus.product, exp);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 8'd0;
        bus.b     = 8'd0;
        #22;
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_done", 16'(bus.done), 16'd0);
        chk("rst_product", bus.product, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(8'd13, 8'd11, 1'b0);
        chk("p_13x11", bus.product, 16'h008F);

        // Asynchronous reset during the 4th iteration discards the operation.
        bus.start = 1'b1;
        bus.a     = 8'd200;
        bus.b     = 8'd100;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 16'(bus.busy), 16'd0);
        chk("arst_done", 16'(bus.done), 16'd0);
        chk("arst_product", bus.product, 16'h0000);
        @(posedge clk); #1;
        chk("arst_hold", 16'(bus.busy), 16'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(8'd2, 8'd3, 1'b0);

        do_op(8'd255, 8'd255, 1'b0);
        chk("p_ffxff", bus.product, 16'hFE01);
        do_op(8'd0, 8'd200, 1'b0);
        do_op(8'd7, 8'd6, 1'b1);
        chk("p_7x6", bus.product, 16'h002A);

        // start held high: done pulses every 10 cycles.
        bus.start = 1'b1;
        bus.a     = 8'd15;
        bus.b     = 8'd17;
        @(posedge clk); #1;
        for (int k = 0; k < 30; k++) begin
            chk("b2b_busy", 16'(bus.busy), 16'((k % 10) < 8));
            chk("b2b_done", 16'(bus.done), 16'((k % 10) == 8));
            if ((k % 10) == 8) chk("b2b_product", bus.product, 16'h00FF);
            if (k == 29) bus.start = 1'b0;
            @(posedge clk); #1;
        end
        chk("b2b_stop", 16'(bus.busy), 16'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i == 5) ra = 8'd0;
            if (i == 9) rb = 8'd0;
            do_op(ra, rb, 1'(i % 3 == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
